inst_queue: RTL and testbench

- Circular FIFO directly downstream of the instruction-fetch stage.
- Accepts one fetched instruction plus its PC per cycle and buffers them.
- Hands them in order, one per cycle, to the decoder/dispatch stage.
- Back-pressures fetch through a registered ready signal; a ROB redirect flushes it.

---
 rtl/inst_queue_pkg.sv | 19 +
 rtl/iq_storage.sv | 26 ++
 rtl/inst_queue.sv | 140 ++++++++++++++
 tb/tb_inst_queue.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared widths and constants for the instruction queue between fetch and decode.
package inst_queue_pkg;

    localparam int   INSTRUCTION_WIDTH = 32;
    localparam int   ADDRESS_WIDTH     = 32;
    localparam logic ENABLE            = 1'b1;
    localparam logic DISABLE           = 1'b0;

    localparam int IQ_DEPTH      = 16;
    localparam int IQ_PTR_BITS   = 4;
    localparam int IQ_RDY_MARGIN = 3;
    localparam int IQ_ENTRY_W    = INSTRUCTION_WIDTH + ADDRESS_WIDTH;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] inst;
        logic [ADDRESS_WIDTH-1:0]     pc;
    } iq_entry_t;

endpackage

// File: rtl/iq_storage.sv
// Entry array for inst_queue: one synchronous write port, one asynchronous read port.
// Zero read latency; no flow control of its own, the owner gates the write enable.
module iq_storage #(
    parameter int DEPTH    = 16,
    parameter int PTR_BITS = 4,
    parameter int WIDTH    = 64
) (
    input  logic                clk_in,
    input  logic                we,
    input  logic [PTR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [PTR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]    rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode; IQ_BYPASS_EN sends an entry straight to decode when empty.
// Latency: 2 edges push-to-decode_en_out (1 edge with IQ_BYPASS_EN); registered ready with RDY_MARGIN free slots.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH      = IQ_DEPTH,
    parameter int PTR_BITS   = IQ_PTR_BITS,
    parameter int RDY_MARGIN = IQ_RDY_MARGIN
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         ifetch_inst_en_in,
    input  logic [INSTRUCTION_WIDTH-1:0] ifetch_inst_in,
    input  logic [ADDRESS_WIDTH-1:0]     ifetch_pc_in,
    output logic                         ifetch_rdy_out,
    input  logic                         decode_rdy_in,
    output logic                         decode_en_out,
    output logic [INSTRUCTION_WIDTH-1:0] decode_inst_out,
    output logic [ADDRESS_WIDTH-1:0]     decode_pc_out,
    input  logic                         rob_en_in
);

    localparam int CNT_W = PTR_BITS + 1;

    logic [PTR_BITS-1:0]          head_q, head_d;
    logic [PTR_BITS-1:0]          tail_q, tail_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         dec_en_q, dec_en_d;
    logic [INSTRUCTION_WIDTH-1:0] dec_inst_q, dec_inst_d;
    logic [ADDRESS_WIDTH-1:0]     dec_pc_q, dec_pc_d;
    logic                         rdy_q, rdy_d;
    logic [15:0]                  ovf_cnt_q, ovf_cnt_d;

    iq_entry_t rd_entry;
    iq_entry_t wr_entry;
    logic      we;
    logic      full;
    logic      pop;
    logic      push_ok;
    logic      bypass;
    logic      drop;

    iq_storage #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS),
        .WIDTH    (IQ_ENTRY_W)
    ) u_storage (
        .clk_in (clk_in),
        .we     (we && !rst_in),
        .waddr  (tail_q),
        .wdata  (wr_entry),
        .raddr  (head_q),
        .rdata  (rd_entry)
    );

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        dec_en_d   = DISABLE;
        dec_inst_d = dec_inst_q;
        dec_pc_d   = dec_pc_q;
        rdy_d      = rdy_q;
        ovf_cnt_d  = ovf_cnt_q;
        we         = 1'b0;
        pop        = 1'b0;
        push_ok    = 1'b0;
        bypass     = 1'b0;
        drop       = 1'b0;
        full       = (count_q == CNT_W'(DEPTH));
        wr_entry   = '{inst: ifetch_inst_in, pc: ifetch_pc_in};

        if (rdy_in) begin
            if (rob_en_in) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                rdy_d   = ENABLE;
            end else begin
                pop = decode_rdy_in && (count_q != '0);
`ifdef IQ_BYPASS_EN
                bypass = ifetch_inst_en_in && decode_rdy_in && (count_q == '0);
`endif
                // A full queue still accepts a push when the same edge frees a slot.
                push_ok = ifetch_inst_en_in && !bypass && (!full || pop);
                drop    = ifetch_inst_en_in && full && !pop;

                if (pop) begin
                    dec_en_d   = ENABLE;
                    dec_inst_d = rd_entry.inst;
                    dec_pc_d   = rd_entry.pc;
                    head_d     = head_q + 1'b1;
                end
                if (bypass) begin
                    dec_en_d   = ENABLE;
                    dec_inst_d = ifetch_inst_in;
                    dec_pc_d   = ifetch_pc_in;
                end
                if (push_ok) begin
                    we     = 1'b1;
                    tail_d = tail_q + 1'b1;
                end
                if (drop) begin
                    ovf_cnt_d = ovf_cnt_q + 1'b1;
                end
                count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
                rdy_d   = (CNT_W'(DEPTH) - count_d) >= CNT_W'(RDY_MARGIN);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            dec_en_q   <= DISABLE;
            dec_inst_q <= '0;
            dec_pc_q   <= '0;
            rdy_q      <= DISABLE;
            ovf_cnt_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            dec_en_q   <= dec_en_d;
            dec_inst_q <= dec_inst_d;
            dec_pc_q   <= dec_pc_d;
            rdy_q      <= rdy_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign ifetch_rdy_out  = rdy_q;
    assign decode_en_out   = dec_en_q;
    assign decode_inst_out = dec_inst_q;
    assign decode_pc_out   = dec_pc_q;

endmodule

// File: tb/tb_inst_queue.sv
// Randomized and directed bench for inst_queue against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH  = 16;
    localparam int MARGIN = 3;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        ifetch_inst_en_in;
    logic [31:0] ifetch_inst_in;
    logic [31:0] ifetch_pc_in;
    logic        ifetch_rdy_out;
    logic        decode_rdy_in;
    logic        decode_en_out;
    logic [31:0] decode_inst_out;
    logic [31:0] decode_pc_out;
    logic        rob_en_in;

    inst_queue dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .ifetch_inst_en_in (ifetch_inst_en_in),
        .ifetch_inst_in    (ifetch_inst_in),
        .ifetch_pc_in      (ifetch_pc_in),
        .ifetch_rdy_out    (ifetch_rdy_out),
        .decode_rdy_in     (decode_rdy_in),
        .decode_en_out     (decode_en_out),
        .decode_inst_out   (decode_inst_out),
        .decode_pc_out     (decode_pc_out),
        .rob_en_in         (rob_en_in)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mq[$];
    logic        m_en;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic        m_rdy;
    int          m_drops;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic en, input logic push,
                              input logic [31:0] inst, input logic [31:0] pc,
                              input logic drdy, input logic rob);
        logic [63:0] e;
        int          n0;
        bit          pop;
        bit          byp;
        if (rst) begin
            mq.delete();
            m_en = 0; m_inst = 0; m_pc = 0; m_rdy = 0; m_drops = 0;
        end else if (!en) begin
            m_en = 0;
        end else if (rob) begin
            mq.delete();
            m_en  = 0;
            m_rdy = 1;
        end else begin
            n0   = mq.size();
            m_en = 0;
            pop  = drdy && (n0 > 0);
            byp  = 0;
`ifdef IQ_BYPASS_EN
            byp = push && drdy && (n0 == 0);
`endif
            if (pop) begin
                e      = mq.pop_front();
                m_en   = 1;
                m_inst = e[63:32];
                m_pc   = e[31:0];
            end
            if (byp) begin
                m_en   = 1;
                m_inst = inst;
                m_pc   = pc;
            end else if (push) begin
                if (n0 < DEPTH || pop) mq.push_back({inst, pc});
                else m_drops++;
            end
            m_rdy = (DEPTH - mq.size()) >= MARGIN;
        end
    endtask

    task automatic cyc(input logic rst, input logic en, input logic push,
                       input logic [31:0] inst, input logic [31:0] pc,
                       input logic drdy, input logic rob);
        rst_in            = rst;
        rdy_in            = en;
        ifetch_inst_en_in = push;
        ifetch_inst_in    = inst;
        ifetch_pc_in      = pc;
        decode_rdy_in     = drdy;
        rob_en_in         = rob;
        @(posedge clk_in);
        model_step(rst, en, push, inst, pc, drdy, rob);
        #1;
        chk("decode_en", 64'(decode_en_out), 64'(m_en));
        chk("decode_inst", 64'(decode_inst_out), 64'(m_inst));
        chk("decode_pc", 64'(decode_pc_out), 64'(m_pc));
        chk("ifetch_rdy", 64'(ifetch_rdy_out), 64'(m_rdy));
        chk("count", 64'(dut.count_q), 64'(mq.size()));
        chk("drops", 64'(dut.ovf_cnt_q), 64'(m_drops));
    endtask

    task automatic push_c(input logic [31:0] pc, input logic drdy);
        cyc(0, 1, 1, $urandom, pc, drdy, 0);
    endtask

    task automatic idle_c(input logic drdy);
        cyc(0, 1, 0, 32'h0, 32'h0, drdy, 0);
    endtask

    initial begin
        logic [31:0] pc;
        logic        pu;

        cyc(1, 1, 1, 32'hdead, 32'hbeef, 1, 1);
        chk("rst_en", 64'(decode_en_out), 64'h0);
        chk("rst_rdy", 64'(ifetch_rdy_out), 64'h0);
        cyc(1, 0, 0, 32'h0, 32'h0, 0, 0);

        // first instruction through
        cyc(0, 1, 1, 32'h00000013, 32'h0, 1, 0);
`ifdef IQ_BYPASS_EN
        chk("t1_en", 64'(decode_en_out), 64'h1);
        chk("t1_inst", 64'(decode_inst_out), 64'h13);
`else
        chk("t1_en_early", 64'(decode_en_out), 64'h0);
        idle_c(1);
        chk("t1_en", 64'(decode_en_out), 64'h1);
        chk("t1_inst", 64'(decode_inst_out), 64'h13);
`endif
        chk("t1_pc", 64'(decode_pc_out), 64'h0);
        idle_c(1);
        idle_c(1);

        // fill to full, then push+pop while full, then an overflowing push
        for (int i = 0; i < 16; i++) begin
            push_c(32'(i * 4), 0);
            if (i == 12) chk("rdy_at13", 64'(ifetch_rdy_out), 64'h1);
            if (i == 13) chk("rdy_at14", 64'(ifetch_rdy_out), 64'h0);
        end
        push_c(32'h40, 1);
        chk("full_pp_cnt", 64'(dut.count_q), 64'd16);
        chk("full_pp_drop", 64'(dut.ovf_cnt_q), 64'd0);
        push_c(32'h44, 0);
        chk("full_drop", 64'(dut.ovf_cnt_q), 64'd1);
        for (int i = 0; i < 18; i++) idle_c(1);
        chk("drained", 64'(dut.count_q), 64'd0);

        // flush with simultaneous push and pop
        for (int i = 0; i < 5; i++) push_c(32'h80 + 32'(i * 4), 0);
        cyc(0, 1, 1, 32'h1234, 32'h200, 1, 1);
        chk("flush_cnt", 64'(dut.count_q), 64'd0);
        chk("flush_en", 64'(decode_en_out), 64'h0);
        chk("flush_rdy", 64'(ifetch_rdy_out), 64'h1);
        push_c(32'h100, 0);
        idle_c(1);
        chk("post_flush_pc", 64'(decode_pc_out), 64'h100);
        idle_c(1);

        // freeze with two entries held
        push_c(32'h300, 0);
        push_c(32'h304, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 32'h55, 32'h999, 1, 0);
            chk("frz_en", 64'(decode_en_out), 64'h0);
            chk("frz_cnt", 64'(dut.count_q), 64'd2);
        end
        idle_c(1);
        chk("rel_pc0", 64'(decode_pc_out), 64'h300);
        idle_c(1);
        chk("rel_pc1", 64'(decode_pc_out), 64'h304);
        idle_c(1);

        // random interleaving, wraps pointers many times
        pc = 32'h1000;
        for (int i = 0; i < 600; i++) begin
            pu = m_rdy && ($urandom_range(3) != 0);
            cyc(0, $urandom_range(11) != 0, pu, $urandom, pc,
                $urandom_range(2) != 0, $urandom_range(63) == 0);
            if (pu) pc = pc + 4;
        end
        for (int i = 0; i < 20; i++) idle_c(1);
        chk("final_cnt", 64'(dut.count_q), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
